seven_seg_scanner: RTL
======================

Name: seven_seg_scanner

Overview:
- Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
- Holds a 32-bit display value and selects one hex nibble per scan slot.
- Drives that nibble to the downstream hex-to-segment decoder, together with the one-hot anode enables and the decimal point.
- Adds frame-synchronous value update (no tearing), optional leading-zero blanking and anode dead-time to suppress ghosting.

Parameters:
- NUM_DIGITS, 8, digits scanned; fixed 8 here (val_in width = 4*NUM_DIGITS).
- COUNT_PERIOD, 100000, clock cycles per digit slot; must be ≥ 2.
- DEAD_CYCLES, 1000, cycles at start of each slot with all anodes off; must be < COUNT_PERIOD.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  synchronous active-low reset
- val_in  input  32  value to display; nibble k shown on digit k
- val_valid_in  input  1  load request; val_in captured when high
- dp_in  input  8  decimal point per digit; 1 = lit
- lz_blank_in  input  1  1 = suppress leading zeros
- digit_out  output  4  nibble for the decoder's bin_in
- digit_sel_out  output  3  index of the digit currently driven
- blank_out  output  1  1 = decoder output must be ignored/segments off
- an_out  output  8  anode enables, active-low, one-hot-low or all-ones
- dp_out  output  1  decimal point, active-low
- frame_done_out  output  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset is synchronous and active-low: clk_in single clock, rst_n_in sampled on rising edge only.
- Reset values:
  - cnt=0, idx=0, shadow=0, active=0, pending=0.
  - an_out=8'hFF, digit_out=0, digit_sel_out=0, blank_out=1, dp_out=1, frame_done_out=0.
  - Reset overrides all other inputs, including mid-frame.
- Slot counter:
  - cnt counts 0..COUNT_PERIOD-1.
  - At cnt==COUNT_PERIOD-1: cnt←0 and idx←idx+1, wrapping NUM_DIGITS-1→0.
- Value load:
  - val_valid_in=1 → shadow←val_in, pending←1.
  - Multiple loads within a frame: last one wins.
- Frame wrap (cnt==COUNT_PERIOD-1 and idx==NUM_DIGITS-1):
  - active←shadow if pending, then pending←0.
  - If val_valid_in is high in the wrap cycle, active←val_in directly (bypass) and pending←0.
  - active never changes at any other time.
- frame_done_out is high for exactly the one cycle following the wrap edge, i.e. the first cycle with idx==0, cnt==0.
- Leading-zero mask, computed combinationally from active:
  - msd = index of the highest nonzero nibble; msd=0 if active==0.
  - Digit k is blanked iff lz_blank_in=1 and k>msd. Digit 0 is never blanked.
- Outputs are registered with 1-cycle latency from (cnt, idx, active):
  - digit_out = active[4*idx +: 4]; digit_sel_out = idx.
  - dead = (cnt < DEAD_CYCLES); blank_out = dead | lzmask[idx].
  - an_out = all ones if blank_out, else ~(1<<idx).
  - dp_out = ~(dp_in[idx] & ~blank_out).
- Invariant: at most one an_out bit is low in any cycle.
- Scan never stalls. A frame lasts NUM_DIGITS*COUNT_PERIOD cycles.

Test Plan:
- Use COUNT_PERIOD=4, DEAD_CYCLES=1 for all scenarios.
- Reset and first frame: hold rst_n_in=0 for 3 cycles, release; val_valid_in pulse with val_in=32'h1234_5678, lz_blank_in=0 → first frame shows active=0. Second frame: digit_out sequence 8,7,6,5,4,3,2,1. an_out=8'hFF in cycle 0 of each slot, then FE,FD,FB,…,7F for cycles 1-3. frame_done_out pulses once per 32 cycles.
- Tearing: load 32'hAAAA_AAAA during frame, then 32'h5555_5555 mid-next-frame → that frame shows all A; the 5s appear only from the following wrap. digit_out is never mixed within a frame.
- Wrap bypass: assert val_valid_in with 32'h0000_00FF exactly in the wrap cycle → the frame beginning next cycle shows F,F,0,… and pending=0.
- Leading zero: val_in=32'h0000_0305, lz_blank_in=1 → digits 0-2 lit (5,0,3); digits 3-7 keep an_out=8'hFF and blank_out=1 for whole slots. val_in=0 → only digit 0 lit showing 0.
- Decimal point: dp_in=8'h04 → dp_out=0 only during non-dead cycles of digit 2; 1 elsewhere, including dead cycles.
- Reset mid-operation: drop rst_n_in at idx=5, cnt=2 → next cycle all outputs at reset values. active=0 and pending cleared; the scan restarts at idx 0.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. A 32-bit value is shown one hex nibble per scan slot. New values
// are taken in at any time but only become visible at a frame boundary, so a
// frame never shows a mix of old and new digits. Optional leading-zero
// blanking and a per-slot anode dead-time (all anodes off) are provided.
//
// Ports
//   clk_in          system clock
//   rst_n_in        synchronous active-low reset
//   val_in          value to display, nibble k on digit k
//   val_valid_in    load strobe, val_in captured while high
//   dp_in           decimal point per digit, 1 = lit
//   lz_blank_in     1 = suppress leading zeros
//   digit_out       nibble for the downstream hex-to-segment decoder
//   digit_sel_out   index of the digit currently driven
//   blank_out       1 = segments must be off / decoder output ignored
//   an_out          anode enables, active-low, one-hot-low or all ones
//   dp_out          decimal point, active-low
//   frame_done_out  one-cycle pulse on the first cycle of each new frame
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
   parameter int NUM_DIGITS   = 8,
   parameter int COUNT_PERIOD = 100000,
   parameter int DEAD_CYCLES  = 1000
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [4*NUM_DIGITS-1:0] val_in,
   input  logic                    val_valid_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_blank_in,
   output logic [3:0]              digit_out,
   output logic [2:0]              digit_sel_out,
   output logic                    blank_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    dp_out,
   output logic                    frame_done_out
);

   localparam int CW = (COUNT_PERIOD > 1) ? $clog2(COUNT_PERIOD) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VW = 4 * NUM_DIGITS;

   localparam logic [CW-1:0] CNT_MAX = CW'(COUNT_PERIOD - 1);
   localparam logic [CW-1:0] DEAD_C  = CW'(DEAD_CYCLES);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic [VW-1:0]         shadow;
   logic [VW-1:0]         active;
   logic                  pending;

   logic                  slot_end;
   logic                  wrap;

   // Next values of the registered outputs, all derived from the current
   // (cnt, idx, active) so every output shares the same one-cycle latency.
   logic [3:0]            digit_next;
   logic                  blank_next;
   logic [NUM_DIGITS-1:0] an_next;
   logic                  dp_next;

   logic [IW-1:0]         msd;
   logic [NUM_DIGITS-1:0] lzmask;

   assign slot_end = (cnt == CNT_MAX);
   assign wrap     = slot_end && (idx == IDX_MAX);

   // ---------------------------------------------------------------------------
   // Leading-zero mask: msd is the highest nonzero nibble (0 for an all-zero
   // value), so digit 0 can never be masked.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // otherwise a path that skips the assignment infers a latch.
      msd    = '0;
      lzmask = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (active[4*k +: 4] != 4'd0) begin
            msd = IW'(k);
         end
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
         lzmask[k] = lz_blank_in && (IW'(k) > msd);
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode for the slot being scanned now.
   // ---------------------------------------------------------------------------
   always_comb begin
      digit_next  = active[{idx, 2'b00} +: 4];
      blank_next  = (cnt < DEAD_C) || lzmask[idx];
      an_next     = '1;
      if (!blank_next) begin
         an_next[idx] = 1'b0;
      end
      dp_next     = ~(dp_in[idx] & ~blank_next);
   end

   // ---------------------------------------------------------------------------
   // Scan counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst_n_in) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Value path: loads land in shadow and are promoted to active only at the
   // frame wrap. A load in the wrap cycle itself goes straight to active.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else begin
         if (val_valid_in) begin
            shadow <= val_in;
         end
         if (wrap) begin
            if (val_valid_in) begin
               active <= val_in;
            end else if (pending) begin
               active <= shadow;
            end
            pending <= 1'b0;
         end else if (val_valid_in) begin
            pending <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         digit_out      <= 4'd0;
         digit_sel_out  <= 3'd0;
         blank_out      <= 1'b1;
         an_out         <= '1;
         dp_out         <= 1'b1;
         frame_done_out <= 1'b0;
      end else begin
         digit_out      <= digit_next;
         digit_sel_out  <= 3'(idx);
         blank_out      <= blank_next;
         an_out         <= an_next;
         dp_out         <= dp_next;
         frame_done_out <= wrap;
      end
   end

endmodule
